// File: rtl/de_regfile_scoreboard.sv
// Decode-stage register file with same-cycle WB bypass and a per-register
// pending-writer scoreboard that drives the combinational issue stall.
module de_regfile_scoreboard #(
  parameter int REGWORDS  = 32,
  parameter int DBITS     = 32,
  parameter int PEND_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_wr_reg,
  input  logic [4:0]       wb_wregno,
  input  logic [DBITS-1:0] wb_regval,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic [DBITS-1:0] rd1,
  output logic [DBITS-1:0] rd2,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic [4:0]       issue_rd,
  input  logic             squash_valid,
  input  logic [4:0]       squash_rd,
  output logic             issue_stall,
  output logic             err_underflow
);

  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  logic [DBITS-1:0]     r_regs [REGWORDS];
  logic [PEND_BITS-1:0] r_pend [REGWORDS];
  logic                 r_err;

  logic                 w_byp1, w_byp2;
  logic                 w_haz1, w_haz2, w_hazd;
  logic                 w_accept;
  logic [PEND_BITS-1:0] w_pend_nxt [REGWORDS];
  logic [REGWORDS-1:0]  w_uf_vec;

  // A single pending write retiring this cycle is covered by the bypass path.
  function automatic logic f_busy(input logic [PEND_BITS-1:0] pend, input logic retire);
    return pend > PEND_BITS'(retire);
  endfunction

  // Net counter update, clamped to [0, max]; MSB flags an underflow.
  function automatic logic [PEND_BITS:0] f_apply(input logic [PEND_BITS-1:0] pend,
                                                 input logic inc, input logic dwb,
                                                 input logic dsq);
    int s;
    s = int'(pend) + int'(inc) - int'(dwb) - int'(dsq);
    if (s < 0)
      return {1'b1, {PEND_BITS{1'b0}}};
    else if (s > int'(PEND_MAX))
      return {1'b0, PEND_MAX};
    else
      return {1'b0, s[PEND_BITS-1:0]};
  endfunction

  always_comb begin
    w_byp1 = wb_wr_reg && (wb_wregno == rs1);
    w_byp2 = wb_wr_reg && (wb_wregno == rs2);
    rd1 = (rs1 == 5'd0) ? '0 : w_byp1 ? wb_regval : reset ? '0 : r_regs[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : w_byp2 ? wb_regval : reset ? '0 : r_regs[rs2];
    w_haz1 = use_rs1 && (rs1 != 5'd0) && f_busy(r_pend[rs1], w_byp1);
    w_haz2 = use_rs2 && (rs2 != 5'd0) && f_busy(r_pend[rs2], w_byp2);
    // Conservative: a full counter stalls even if a WB retires one this cycle.
    w_hazd = issue_wr && (issue_rd != 5'd0) && (r_pend[issue_rd] == PEND_MAX);
    issue_stall = !reset && issue_valid && (w_haz1 || w_haz2 || w_hazd);
    w_accept = issue_valid && !issue_stall;
  end

  always_comb begin
    w_uf_vec = '0;
    w_pend_nxt[0] = '0;
    for (int r = 1; r < REGWORDS; r++) begin
      {w_uf_vec[r], w_pend_nxt[r]} = f_apply(r_pend[r],
        w_accept && issue_wr && (issue_rd == 5'(r)),
        wb_wr_reg && (wb_wregno == 5'(r)),
        squash_valid && (squash_rd == 5'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REGWORDS; r++) begin
        r_regs[r] <= '0;
        r_pend[r] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int r = 1; r < REGWORDS; r++) begin
        if (wb_wr_reg && (wb_wregno == 5'(r)))
          r_regs[r] <= wb_regval;
        r_pend[r] <= w_pend_nxt[r];
      end
      r_err <= r_err || (|w_uf_vec);
    end
  end

  assign err_underflow = r_err;

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Bench for de_regfile_scoreboard: directed scenarios with literal expectations,
// then random traffic checked every cycle against an array/arithmetic model.
module tb_de_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_wr_reg;
  logic [4:0]  wb_wregno;
  logic [31:0] wb_regval;
  logic [4:0]  rs1, rs2;
  logic        use_rs1, use_rs2;
  logic [31:0] rd1, rd2;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_rd;
  logic        squash_valid;
  logic [4:0]  squash_rd;
  logic        issue_stall, err_underflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg [32];
  int          mpend [32];
  logic        merr;
  bit          armed = 1'b0;

  de_regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .wb_regval(wb_regval),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd1(rd1), .rd2(rd2),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .squash_valid(squash_valid), .squash_rd(squash_rd),
    .issue_stall(issue_stall), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (wb_wr_reg && wb_wregno == rs) return wb_regval;
    if (reset) return 32'h0;
    return mreg[rs];
  endfunction

  function automatic bit m_src_haz(input bit use_it, input logic [4:0] rs);
    int retire;
    retire = (wb_wr_reg && wb_wregno == rs) ? 1 : 0;
    return use_it && rs != 0 && (mpend[rs] - retire > 0);
  endfunction

  function automatic bit m_stall();
    bit dst;
    dst = issue_wr && issue_rd != 0 && mpend[issue_rd] == 3;
    return !reset && issue_valid &&
           (m_src_haz(use_rs1, rs1) || m_src_haz(use_rs2, rs2) || dst);
  endfunction

  // Reference state update.
  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        mreg[r] = 32'h0;
        mpend[r] = 0;
      end
      merr = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      int  d [32];
      bit  acc;
      acc = issue_valid && !m_stall();
      for (int r = 0; r < 32; r++) d[r] = 0;
      if (acc && issue_wr) d[issue_rd] += 1;
      if (wb_wr_reg) d[wb_wregno] -= 1;
      if (squash_valid) d[squash_rd] -= 1;
      if (wb_wr_reg && wb_wregno != 0) mreg[wb_wregno] = wb_regval;
      for (int r = 1; r < 32; r++) begin
        int n;
        n = mpend[r] + d[r];
        if (n < 0) begin
          merr = 1'b1;
          n = 0;
        end
        mpend[r] = n;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_rd1", rd1, m_rd(rs1));
      chk("cyc_rd2", rd2, m_rd(rs2));
      chk("cyc_stall", 32'(issue_stall), 32'(m_stall()));
      chk("cyc_err", 32'(err_underflow), 32'(merr));
    end
  end

  task automatic idle();
    wb_wr_reg = 0; wb_wregno = 0; wb_regval = 0;
    rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0;
    issue_valid = 0; issue_wr = 0; issue_rd = 0;
    squash_valid = 0; squash_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_w(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;

    // Post-reset reads
    rs1 = 5; rs2 = 6; use_rs1 = 1; use_rs2 = 1; issue_valid = 1;
    #2;
    chk("t1_rd1", rd1, 32'h0);
    chk("t1_rd2", rd2, 32'h0);
    chk("t1_stall", 32'(issue_stall), 32'h0);
    chk("t1_err", 32'(err_underflow), 32'h0);
    tick();

    // RAW hazard on x5 released by same-cycle WB
    issue_w(5);
    tick();
    idle();
    issue_valid = 1; rs1 = 5; use_rs1 = 1;
    #2;
    chk("t2_stall", 32'(issue_stall), 32'h1);
    wb_wr_reg = 1; wb_wregno = 5; wb_regval = 32'hDEADBEEF;
    #1;
    chk("t2_stall_byp", 32'(issue_stall), 32'h0);
    chk("t2_rd1_byp", rd1, 32'hDEADBEEF);
    tick();

    // x0 writes are discarded
    idle();
    wb_wr_reg = 1; wb_wregno = 0; wb_regval = 32'h1234; rs2 = 0; use_rs2 = 1;
    #2;
    chk("t3_rd2", rd2, 32'h0);
    tick();
    idle();
    #2;
    chk("t3_rd2_next", rd2, 32'h0);
    chk("t3_err", 32'(err_underflow), 32'h0);

    // Counter saturation on x7
    for (int i = 0; i < 3; i++) begin
      issue_w(7);
      #2;
      chk("t4_fill_stall", 32'(issue_stall), 32'h0);
      tick();
    end
    issue_w(7);
    #2;
    chk("t4_full_stall", 32'(issue_stall), 32'h1);
    wb_wr_reg = 1; wb_wregno = 7; wb_regval = 32'h77;
    #1;
    chk("t4_full_wb_stall", 32'(issue_stall), 32'h1);
    tick();
    issue_w(7);
    #2;
    chk("t4_after_wb_stall", 32'(issue_stall), 32'h0);
    tick();
    idle();
    rs1 = 7;
    #2;
    chk("t4_rd1_x7", rd1, 32'h77);

    // Issue + WB + squash on x9 with count 2
    issue_w(9);
    tick();
    issue_w(9);
    tick();
    issue_w(9);
    wb_wr_reg = 1; wb_wregno = 9; wb_regval = 32'h99;
    squash_valid = 1; squash_rd = 9;
    #2;
    chk("t5_stall", 32'(issue_stall), 32'h0);
    tick();
    idle();
    issue_valid = 1; rs1 = 9; use_rs1 = 1;
    #2;
    chk("t5_src_stall", 32'(issue_stall), 32'h1);
    tick();

    // Underflow on x3, then reset during a would-be stall
    idle();
    wb_wr_reg = 1; wb_wregno = 3; wb_regval = 32'hCAFE0003;
    tick();
    idle();
    rs1 = 3;
    #2;
    chk("t6_err", 32'(err_underflow), 32'h1);
    chk("t6_rd1", rd1, 32'hCAFE0003);
    tick();
    #2;
    chk("t6_err_held", 32'(err_underflow), 32'h1);
    issue_w(7);
    reset = 1;
    #1;
    chk("t6_rst_stall", 32'(issue_stall), 32'h0);
    tick();
    reset = 0;
    idle();
    rs1 = 3;
    #2;
    chk("t6_err_clr", 32'(err_underflow), 32'h0);
    chk("t6_rd1_clr", rd1, 32'h0);
    tick();

    // Random traffic concentrated on x0..x7
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(63) == 0);
      wb_wr_reg    = ($urandom_range(2) == 0);
      wb_wregno    = 5'($urandom_range(7));
      wb_regval    = $urandom;
      rs1          = 5'($urandom_range(7));
      rs2          = 5'($urandom_range(7));
      use_rs1      = 1'($urandom_range(1));
      use_rs2      = 1'($urandom_range(1));
      issue_valid  = ($urandom_range(3) != 0);
      issue_wr     = 1'($urandom_range(1));
      issue_rd     = 5'($urandom_range(7));
      squash_valid = ($urandom_range(5) == 0);
      squash_rd    = 5'($urandom_range(7));
      tick();
    end
    reset = 0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
